// File: rtl/serial_pkg.sv
// Shared encodings and helpers for the serial pattern transmitter.
// Pulled in by the top and the counter with import serial_pkg::*.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // The counter must hold both WIDTH-1 (bit count) and GAP_CYCLES-1 (gap count).
    function automatic int cnt_width(input int width, input int gap_cycles);
        int m;
        m = (width > gap_cycles + 1) ? width : gap_cycles + 1;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with a zero flag.
// It stops at zero instead of wrapping; every state entry reloads it.
module tx_down_counter
    import serial_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    // Load takes priority over decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial transmitter feeding the sequence detector's x input.
// It sends one word per handshake, inserts an idle gap, and can repeat the held word.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int   WIDTH      = 32,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             repeat_en,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int            CW         = cnt_width(WIDTH, GAP_CYCLES);
    localparam bit            HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] WIDTH_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LOAD   = HAS_GAP ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_x_out;
    logic             r_bit_valid;
    logic             r_frame_start;
    logic             r_frame_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             w_x_nxt;
    logic             w_bv_nxt;
    logic             w_fs_nxt;
    logic             w_fd_nxt;
    logic             w_cnt_load;
    logic [CW-1:0]    w_cnt_load_val;
    logic             w_cnt_en;
    logic [CW-1:0]    w_cnt;
    logic             w_cnt_zero;
    logic             w_data_ready;

    // Handshake: a word transfers on a posedge where data_valid && data_ready;
    // data_ready depends only on the state register, never on data_valid.
    assign w_data_ready = (r_state == ST_IDLE);
    assign data_ready   = w_data_ready;
    assign busy         = !w_data_ready;
    assign o_dbg_state  = r_state;
    assign x_out        = r_x_out;
    assign bit_valid    = r_bit_valid;
    assign frame_start  = r_frame_start;
    assign frame_done   = r_frame_done;

    tx_down_counter #(
        .CW(CW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // r_shift holds the bits still to send, already advanced past the bit on x_out.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_hold_nxt     = r_hold;
        w_x_nxt        = IDLE_BIT;
        w_bv_nxt       = 1'b0;
        w_fs_nxt       = 1'b0;
        w_fd_nxt       = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = WIDTH_LOAD;
        w_cnt_en       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (data_valid && w_data_ready) begin
                    w_hold_nxt  = data_in;
                    w_shift_nxt = {data_in[WIDTH-2:0], 1'b0};
                    w_x_nxt     = data_in[WIDTH-1];
                    w_bv_nxt    = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_cnt_zero) begin
                    w_x_nxt     = r_shift[WIDTH-1];
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    w_bv_nxt    = 1'b1;
                    w_fd_nxt    = (w_cnt == CNT_ONE);
                    w_cnt_en    = 1'b1;
                end else if (HAS_GAP) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = GAP_LOAD;
                    w_state_nxt    = ST_GAP;
                end else if (repeat_en) begin
                    w_shift_nxt = {r_hold[WIDTH-2:0], 1'b0};
                    w_x_nxt     = r_hold[WIDTH-1];
                    w_bv_nxt    = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!w_cnt_zero) begin
                    w_cnt_en = 1'b1;
                end else if (repeat_en) begin
                    w_shift_nxt = {r_hold[WIDTH-2:0], 1'b0};
                    w_x_nxt     = r_hold[WIDTH-1];
                    w_bv_nxt    = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_hold        <= '0;
            r_x_out       <= IDLE_BIT;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_hold        <= w_hold_nxt;
            r_x_out       <= w_x_nxt;
            r_bit_valid   <= w_bv_nxt;
            r_frame_start <= w_fs_nxt;
            r_frame_done  <= w_fd_nxt;
        end
    end

endmodule
